uart_rx_deframer: RTL and testbench
===================================

UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

Interface
REQ-001 SHALL have parameter DBIT, default 8, data bits per frame (5..9).
REQ-002 SHALL have parameter SB_TICK, default 16, s_tick count for the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port s_tick  input  1  one-clk strobe at 16x baud, from the baud timer.
REQ-007 SHALL have port rx_dout  output  DBIT  last received data word, LSB first on the line.
REQ-008 SHALL have port rx_done_tick  output  1  one-clk pulse, frame complete; feeds FIFO wr_en.
REQ-009 SHALL have port frame_err  output  1  stop bit sampled low; valid with rx_done_tick.
REQ-010 SHALL have port parity_err  output  1  parity mismatch; valid with rx_done_tick.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer reset to 1; the FSM uses only the synchronized rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP with a 4-bit tick counter s and a bit counter n of width clog2(DBIT).
REQ-013 IDLE: rx_s == 0 -> START with s = 0; otherwise hold.
REQ-014 START: on s_tick with s == 7, rx_s == 0 -> DATA, s = 0, n = 0; rx_s == 1 -> IDLE (glitch reject) with no output pulse.
REQ-015 DATA: on s_tick with s == 15, shift rx_s into the MSB of the shift register, s = 0; at n == DBIT-1 -> PARITY if enabled, otherwise STOP; else n++.
REQ-016 PARITY: on s_tick with s == 15, compare rx_s against the computed parity, s = 0, then -> STOP.
REQ-017 STOP: on s_tick with s == SB_TICK-1, go to IDLE; in that same clk, pulse rx_done_tick, load rx_dout, and set frame_err = ~rx_s and parity_err as computed.
REQ-018 Without s_tick, the FSM and counters SHALL hold; s increments only on s_tick.
REQ-019 rx_done_tick SHALL pulse for every completed frame, including frames with frame_err or parity_err set.
REQ-020 rx_dout, frame_err and parity_err SHALL hold until the next rx_done_tick.
REQ-021 Latency: rx_done_tick SHALL occur exactly one clk after the s_tick that completes the stop sample.
REQ-022 A low rx_s in STOP (break condition) SHALL return the FSM to IDLE, which then re-arms on the low line; this is defined behaviour, not an error.

Reset
REQ-023 On reset_n low, asynchronously: state = IDLE, s = 0, n = 0, shift register = 0, rx_dout = 0, rx_done_tick = 0, frame_err = 0, parity_err = 0, synchronizer = 1.
REQ-024 Reset mid-frame SHALL discard the partial frame and produce no rx_done_tick.

Configuration
REQ-025 With UART_RX_PARITY_EN defined: the PARITY state SHALL exist; parameter PARITY_ODD (default 0) SHALL select even (0) or odd (1) parity.
REQ-026 Without UART_RX_PARITY_EN: the PARITY state SHALL be absent, DATA SHALL go directly to STOP, and parity_err SHALL be tied to 0.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state enumeration, the OVERSAMPLE = 16 constant, and the default DBIT and SB_TICK values.
REQ-028 The synchronizer SHALL be a separate sub-module, uart_sync2 (1-bit, reset value parameterized).

Verification (s_tick every 4 clk, DBIT = 8, SB_TICK = 16)
REQ-029 Frame 0xA5 with valid stop bit -> exactly one rx_done_tick, rx_dout = 0xA5, frame_err = 0.
REQ-030 Low glitch on rx for 5 s_ticks -> FSM returns to IDLE, no rx_done_tick.
REQ-031 Frame 0x3C with stop bit low -> rx_done_tick, rx_dout = 0x3C, frame_err = 1.
REQ-032 Parity enabled (even): frame 0x01 with parity bit 0 -> parity_err = 1; with parity bit 1 -> parity_err = 0.
REQ-033 reset_n pulsed low during data bit 4 of 0xFF, then frame 0x55 -> no pulse for the aborted frame, then rx_dout = 0x55.
REQ-034 Frames 0x00, 0xFF, 0x81 back-to-back with no idle gap -> three rx_done_ticks, data in order, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state codes,
// oversampling ratio and default frame parameters.
package uart_pkg;

    localparam int OVERSAMPLE      = 16;
    localparam int DEFAULT_DBIT    = 8;
    localparam int DEFAULT_SB_TICK = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset
// to RESET_VAL so an idle-high line does not look like a start bit.
module uart_sync2 #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments keep the two stages a true shift
    // register; blocking ones would collapse them into a single flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receiver: 16x oversampled start/data/stop deframing with frame error
// flag. Define UART_RX_PARITY_EN to add a parity bit check (PARITY_ODD).
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int DBIT    = DEFAULT_DBIT,
    parameter int SB_TICK = DEFAULT_SB_TICK
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    localparam int NW = $clog2(DBIT);
    // Tick counter is 4 bits for one stop bit; 1.5 or 2 stop bits need 5.
    localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;

    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic            rx_s;
    state_t          state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;

    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (rx),
        .q      (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_err_r;
    logic par_exp;

    // Expected line bit: even parity makes the total count of ones even.
    assign par_exp = (^b) ^ PARITY_ODD;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            rx_dout      <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_r    <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        s     <= '0;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (s == S_MID) begin
                            // Line back high at mid start bit: a glitch, not a frame.
                            if (!rx_s) begin
                                state <= ST_DATA;
                                s     <= '0;
                                n     <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (s == S_BIT) begin
                            s <= '0;
                            b <= {rx_s, b[DBIT-1:1]};
                            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (s_tick) begin
                        if (s == S_BIT) begin
                            s         <= '0;
                            par_err_r <= (rx_s != par_exp);
                            state     <= ST_STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (s_tick) begin
                        if (s == S_STOP) begin
                            // A low stop (break) still completes the frame; IDLE
                            // re-arms on the low line afterwards.
                            state        <= ST_IDLE;
                            rx_done_tick <= 1'b1;
                            rx_dout      <= b;
                            frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err   <= par_err_r;
`endif
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: s_tick every 4 clk, DBIT = 8,
// SB_TICK = 16; parity scenario only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_deframer;
    import uart_pkg::*;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx      = 1'b1;
    logic       s_tick  = 1'b0;
    logic [7:0] rx_dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] dout_q[$];
    logic       ferr_q[$];
    logic       perr_q[$];
    logic       done_prev = 1'b0;

`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_deframer #(
        .DBIT   (8),
        .SB_TICK(16)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD(1'b0)
`endif
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .s_tick      (s_tick),
        .rx_dout     (rx_dout),
        .rx_done_tick(rx_done_tick),
        .frame_err   (frame_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            s_tick = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    // Capture every completed frame and confirm the done strobe is one clk wide.
    always @(negedge clk) begin
        if (rx_done_tick) begin
            checks++;
            if (done_prev !== 1'b0) begin
                errors++;
                $display("FAIL done_width: rx_done_tick high %0d consecutive clks, want 1", 2);
            end
            dout_q.push_back(rx_dout);
            ferr_q.push_back(frame_err);
            perr_q.push_back(parity_err);
        end
        done_prev = rx_done_tick;
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ticks(input int nt);
        int k;
        k = 0;
        while (k < nt) begin
            @(posedge clk);
            if (s_tick) k++;
        end
    endtask

    task automatic drive_bit(input logic v, input int nt);
        @(negedge clk);
        rx = v;
        wait_ticks(nt);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_val, input int stop_ticks);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(data[i], 16);
`ifdef UART_RX_PARITY_EN
        drive_bit((^data) ^ par_flip, 16);
`endif
        drive_bit(stop_val, stop_ticks);
    endtask

    task automatic clear_capture();
        dout_q.delete();
        ferr_q.delete();
        perr_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx      = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (rx_dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", rx_dout); end
        checks++;
        if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", rx_done_tick); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        checks++;
        if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", parity_err); end
        checks++;
        if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dut.state, ST_IDLE); end
        reset_n = 1'b1;
        drive_bit(1'b1, 8);
    endtask

    task automatic test_valid_frame();
        clear_capture();
        send_frame(8'hA5, 1'b1, 16);
        drive_bit(1'b1, 16);
        checks++;
        if (dout_q.size() !== 1) begin errors++; $display("FAIL a5_count: got %0d pulses want 1", dout_q.size()); end
        checks++;
        if (dout_q[0] !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h want a5", dout_q[0]); end
        checks++;
        if (ferr_q[0] !== 1'b0) begin errors++; $display("FAIL a5_ferr: got %b want 0", ferr_q[0]); end
        checks++;
        if (perr_q[0] !== 1'b0) begin errors++; $display("FAIL a5_perr: got %b want 0", perr_q[0]); end
    endtask

    task automatic test_glitch();
        clear_capture();
        drive_bit(1'b0, 5);
        drive_bit(1'b1, 16);
        checks++;
        if (dout_q.size() !== 0) begin errors++; $display("FAIL glitch_count: got %0d pulses want 0", dout_q.size()); end
        checks++;
        if (dut.state !== ST_IDLE) begin errors++; $display("FAIL glitch_state: got %0d want %0d", dut.state, ST_IDLE); end
    endtask

    task automatic test_frame_err();
        clear_capture();
        // Stop held low long enough to be sampled, released before the re-armed
        // start check so the break does not turn into a second frame.
        send_frame(8'h3C, 1'b0, 12);
        drive_bit(1'b1, 24);
        checks++;
        if (dout_q.size() !== 1) begin errors++; $display("FAIL ferr_count: got %0d pulses want 1", dout_q.size()); end
        checks++;
        if (dout_q[0] !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h want 3c", dout_q[0]); end
        checks++;
        if (ferr_q[0] !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", ferr_q[0]); end
        drive_bit(1'b1, 32);
        checks++;
        if ({rx_dout, frame_err} !== {8'h3C, 1'b1}) begin
            errors++;
            $display("FAIL ferr_hold: got %h/%b want 3c/1", rx_dout, frame_err);
        end
        checks++;
        if (dout_q.size() !== 1) begin errors++; $display("FAIL break_rearm: got %0d pulses want 1", dout_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        clear_capture();
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
        drive_bit(1'b1, 8);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_dout !== 8'h00) begin errors++; $display("FAIL midrst_dout: got %h want 00", rx_dout); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_ferr: got %b want 0", frame_err); end
        reset_n = 1'b1;
        wait_ticks(8 + 16 * 3 + 16 + 16);
        checks++;
        if (dout_q.size() !== 0) begin errors++; $display("FAIL midrst_count: got %0d pulses want 0", dout_q.size()); end
        send_frame(8'h55, 1'b1, 16);
        drive_bit(1'b1, 16);
        checks++;
        if (dout_q.size() !== 1) begin errors++; $display("FAIL post_rst_count: got %0d pulses want 1", dout_q.size()); end
        checks++;
        if (dout_q[0] !== 8'h55) begin errors++; $display("FAIL post_rst_data: got %h want 55", dout_q[0]); end
        checks++;
        if (ferr_q[0] !== 1'b0) begin errors++; $display("FAIL post_rst_ferr: got %b want 0", ferr_q[0]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_data[3];
        exp_data = '{8'h00, 8'hFF, 8'h81};
        clear_capture();
        for (int i = 0; i < 3; i++) send_frame(exp_data[i], 1'b1, 16);
        drive_bit(1'b1, 16);
        checks++;
        if (dout_q.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d pulses want 3", dout_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout_q[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL b2b_data%0d: got %h want %h", i, dout_q[i], exp_data[i]);
            end
            checks++;
            if (ferr_q[i] !== 1'b0) begin errors++; $display("FAIL b2b_ferr%0d: got %b want 0", i, ferr_q[i]); end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_capture();
        par_flip = 1'b1;
        send_frame(8'h01, 1'b1, 16);
        drive_bit(1'b1, 16);
        par_flip = 1'b0;
        send_frame(8'h01, 1'b1, 16);
        drive_bit(1'b1, 16);
        checks++;
        if (dout_q.size() !== 2) begin errors++; $display("FAIL par_count: got %0d pulses want 2", dout_q.size()); end
        checks++;
        if (perr_q[0] !== 1'b1) begin errors++; $display("FAIL par_bad: got %b want 1", perr_q[0]); end
        checks++;
        if (perr_q[1] !== 1'b0) begin errors++; $display("FAIL par_good: got %b want 0", perr_q[1]); end
        checks++;
        if (dout_q[1] !== 8'h01) begin errors++; $display("FAIL par_data: got %h want 01", dout_q[1]); end
    endtask
`endif

    initial begin
        test_reset();
        test_valid_frame();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
